bounce_box: RTL
===============

BOUNCE_BOX -- requirements
Module: bounce_box

Interface
REQ-001 Parameter BOX_SIZE, default 32, box edge length in pixels.
REQ-002 Parameter SPEED, default 2, pixels moved per axis per frame.
REQ-003 Elaboration SHALL fail unless 1 <= BOX_SIZE <= 479 and 1 <= SPEED <= 63.
REQ-004 vgaclk  input  1  pixel clock; the only clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 hc  input  10  horizontal pixel counter from the VGA timing stage (0..799).
REQ-007 vc  input  10  vertical line counter from the VGA timing stage (0..524).
REQ-008 pause  input  1  high freezes box motion.
REQ-009 out_red  output  3  pixel red for the VGA stage.
REQ-010 out_green  output  3  pixel green.
REQ-011 out_blue  output  2  pixel blue.
REQ-012 frame_tick  output  1  one-cycle pulse per frame, registered.
REQ-013 bounce_count  output  8  frames containing a bounce, saturating.

Function
REQ-014 State registers: x[9:0], y[9:0], dir_x (1 = increasing), dir_y, color_idx[2:0], bounce_count[7:0].
REQ-015 Update point is the cycle with hc==640 and vc==480; on that clock edge frame_tick <= 1, otherwise frame_tick <= 0.
REQ-016 At the update edge with pause low, each axis moves by SPEED per REQ-017..REQ-019; with pause high, no state changes except frame_tick.
REQ-017 X increasing: if x+BOX_SIZE+SPEED >= 640 then x <= 640-BOX_SIZE, dir_x <= 0, bounce; else x <= x+SPEED.
REQ-018 X decreasing: if x <= SPEED then x <= 0, dir_x <= 1, bounce; else x <= x-SPEED.
REQ-019 Y is identical, with limit 480 in place of 640.
REQ-020 Arithmetic for REQ-017..REQ-019 SHALL use at least 11 bits; no wrap is permitted.
REQ-021 A bounce on either or both axes in one update SHALL increment color_idx by exactly 1 (mod 8) and bounce_count by exactly 1, saturating at 255.
REQ-022 Pixel output is combinational from hc, vc and registered state (zero latency, aligned with the VGA stage).
REQ-023 Inside box: hc<640, vc<480, x <= hc < x+BOX_SIZE, y <= vc < y+BOX_SIZE.
REQ-024 Inside box, output palette[color_idx] as r/g/b: 0 7/0/0, 1 0/7/0, 2 0/0/3, 3 7/7/0, 4 0/7/3, 5 7/0/3, 6 7/7/3, 7 7/3/0.
REQ-025 Outside box, including all blanking positions, outputs SHALL be 0/0/0.
REQ-026 hc/vc values outside 0..799/0..524 SHALL cause no state change except per REQ-015.

Reset
REQ-027 rst high at a vgaclk edge: x=0, y=0, dir_x=1, dir_y=1, color_idx=0, bounce_count=0, frame_tick=0.
REQ-028 rst overrides an update point in the same cycle; no frame_tick is emitted.
REQ-029 Reset mid-frame SHALL take effect on the next edge; pixel output for that frame reflects reset state immediately after.

Verification
REQ-030 Reset, then hc=0,vc=0 -> 7/0/0; hc=32,vc=0 -> 0/0/0; bounce_count=0.
REQ-031 One update (pause=0) -> frame_tick high exactly one cycle; hc=1,vc=1 -> 0/0/0; hc=2,vc=2 -> 7/0/0.
REQ-032 From reset, 224 updates -> y=448, dir_y=0, x=448, bounce_count=1, color 0/7/0; 304 updates -> x=608, dir_x=0, bounce_count=2, color 0/0/3.
REQ-033 pause=1 across 3 update points -> 3 frame_tick pulses; x, y, color_idx, and bounce_count unchanged.
REQ-034 Box state covering hc=700 region, drive hc=700,vc=10 and hc=10,vc=500 -> 0/0/0.
REQ-035 10 updates, then rst for one cycle mid-frame -> x=0, y=0, count=0; hc=0,vc=0 -> 7/0/0; next update lands the box at (2,2).

Source files
------------

// File: rtl/bounce_box_if.sv
// VGA-side signal bundle for bounce_box: pixel/line position and pause in,
// pixel colour, frame tick and bounce counter out.
interface bounce_box_if;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       pause;
    logic [2:0] out_red;
    logic [2:0] out_green;
    logic [1:0] out_blue;
    logic       frame_tick;
    logic [7:0] bounce_count;

    modport master (
        output hc, vc, pause,
        input  out_red, out_green, out_blue, frame_tick, bounce_count
    );

    modport slave (
        input  hc, vc, pause,
        output out_red, out_green, out_blue, frame_tick, bounce_count
    );
endinterface

// File: rtl/bounce_box.sv
// Bouncing coloured square for a 640x480 VGA raster; the position advances once
// per frame at the first blanking pixel and the colour steps on every bounce.
module bounce_box #(
    parameter int BOX_SIZE = 32,
    parameter int SPEED    = 2
) (
    input  logic         vgaclk,
    input  logic         rst,
    bounce_box_if.slave  vga
);

    if (BOX_SIZE < 1 || BOX_SIZE > 479 || SPEED < 1 || SPEED > 63) begin : g_param_check
        $error("bounce_box: BOX_SIZE must be 1..479 and SPEED 1..63");
    end

    localparam logic [10:0] H_ACT = 11'd640;
    localparam logic [10:0] V_ACT = 11'd480;
    localparam logic [10:0] BOX   = 11'(BOX_SIZE);
    localparam logic [10:0] SPD   = 11'(SPEED);

    // Returns {hit, next_dir, next_pos}; 11-bit math keeps the edge test wrap-free.
    function automatic logic [11:0] step_axis(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [10:0] lim);
        logic [10:0] p;
        p = {1'b0, pos};
        if (dir) begin
            if (p + BOX + SPD >= lim) return {1'b1, 1'b0, 10'(lim - BOX)};
            else                      return {1'b0, 1'b1, 10'(p + SPD)};
        end else begin
            if (p <= SPD) return {1'b1, 1'b1, 10'd0};
            else          return {1'b0, 1'b0, 10'(p - SPD)};
        end
    endfunction

    function automatic logic [7:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return {3'd7, 3'd0, 2'd0};
            3'd1:    return {3'd0, 3'd7, 2'd0};
            3'd2:    return {3'd0, 3'd0, 2'd3};
            3'd3:    return {3'd7, 3'd7, 2'd0};
            3'd4:    return {3'd0, 3'd7, 2'd3};
            3'd5:    return {3'd7, 3'd0, 2'd3};
            3'd6:    return {3'd7, 3'd7, 2'd3};
            default: return {3'd7, 3'd3, 2'd0};
        endcase
    endfunction

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [2:0]  r_color_idx;
    logic [7:0]  r_bounce_count;
    logic        r_frame_tick;

    logic [11:0] w_nx;
    logic [11:0] w_ny;
    logic        w_update;
    logic        w_hit;
    logic [10:0] w_hc;
    logic [10:0] w_vc;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_inside;
    logic [7:0]  w_rgb;

    always_comb begin
        w_nx     = step_axis(r_x, r_dir_x, H_ACT);
        w_ny     = step_axis(r_y, r_dir_y, V_ACT);
        w_update = (vga.hc == 10'd640) && (vga.vc == 10'd480);
        w_hit    = w_nx[11] | w_ny[11];
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            r_x            <= 10'd0;
            r_y            <= 10'd0;
            r_dir_x        <= 1'b1;
            r_dir_y        <= 1'b1;
            r_color_idx    <= 3'd0;
            r_bounce_count <= 8'd0;
            r_frame_tick   <= 1'b0;
        end else begin
            r_frame_tick <= w_update;
            if (w_update && !vga.pause) begin
                r_x     <= w_nx[9:0];
                r_dir_x <= w_nx[10];
                r_y     <= w_ny[9:0];
                r_dir_y <= w_ny[10];
                // Simultaneous X and Y bounces count as a single event.
                if (w_hit) begin
                    r_color_idx <= r_color_idx + 3'd1;
                    if (r_bounce_count != 8'hFF) r_bounce_count <= r_bounce_count + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_hc     = {1'b0, vga.hc};
        w_vc     = {1'b0, vga.vc};
        w_x      = {1'b0, r_x};
        w_y      = {1'b0, r_y};
        w_inside = (w_hc < H_ACT) && (w_vc < V_ACT) &&
                   (w_hc >= w_x) && (w_hc < w_x + BOX) &&
                   (w_vc >= w_y) && (w_vc < w_y + BOX);
        w_rgb    = w_inside ? palette(r_color_idx) : 8'd0;
    end

    assign vga.out_red      = w_rgb[7:5];
    assign vga.out_green    = w_rgb[4:2];
    assign vga.out_blue     = w_rgb[1:0];
    assign vga.frame_tick   = r_frame_tick;
    assign vga.bounce_count = r_bounce_count;

endmodule
